// File: rtl/vending_ctrl_multi_if.sv
// rtl/vending_ctrl_multi_if.sv - coin/button front end and dispenser/hopper signals of vending_ctrl_multi
interface vending_ctrl_multi_if #(
    parameter int N_ITEMS  = 4,
    parameter int CREDIT_W = 8,
    parameter int ITEM_W   = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
);
    logic                coin_5;
    logic                coin_10;
    logic                coin_25;
    logic [N_ITEMS-1:0]  select;
    logic                refund;
    logic                dispense;
    logic [ITEM_W-1:0]   dispense_item;
    logic                change_valid;
    logic [CREDIT_W-1:0] change_amt;
    logic [CREDIT_W-1:0] credit;
    logic [N_ITEMS-1:0]  sold_out;
    logic                coin_reject;

    modport master (
        output coin_5, coin_10, coin_25, select, refund,
        input  dispense, dispense_item, change_valid, change_amt, credit, sold_out, coin_reject
    );

    modport slave (
        input  coin_5, coin_10, coin_25, select, refund,
        output dispense, dispense_item, change_valid, change_amt, credit, sold_out, coin_reject
    );
endinterface

// File: rtl/vending_ctrl_multi.sv
// rtl/vending_ctrl_multi.sv - multi-item vending controller; COIN_FILTER_EN enables the coin glitch filter
module vending_ctrl_multi #(
    parameter int N_ITEMS       = 4,
    parameter int PRICE_BASE    = 25,
    parameter int PRICE_STEP    = 10,
    parameter int CREDIT_W      = 8,
    parameter int MAX_CREDIT    = 100,
    parameter int STOCK_W       = 4,
    parameter int STOCK_INIT    = 3,
    parameter int FILTER_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    vending_ctrl_multi_if.slave  bus
);
    localparam int ITEM_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
    localparam int SUM_W  = CREDIT_W + 1;

    typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

    state_t              state;
    logic [CREDIT_W-1:0] credit_r;
    logic [STOCK_W-1:0]  stock [N_ITEMS];
    logic [ITEM_W-1:0]   item_r;

    logic [2:0] coin_raw;
    logic [2:0] level;
    logic [2:0] level_prev;
    logic [2:0] events;

    assign coin_raw = {bus.coin_25, bus.coin_10, bus.coin_5};

    function automatic logic [SUM_W-1:0] price(input int idx);
        return SUM_W'(PRICE_BASE + idx * PRICE_STEP);
    endfunction

`ifdef COIN_FILTER_EN
    localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
    logic [CNT_W-1:0] cnt [3];

    // Saturating run-length counter: level asserts only after FILTER_CYCLES high samples.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!reset)
                cnt[i] <= coin_raw[i] ? CNT_W'(FILTER_CYCLES) : '0;
            else if (!coin_raw[i])
                cnt[i] <= '0;
            else if (cnt[i] != CNT_W'(FILTER_CYCLES))
                cnt[i] <= cnt[i] + CNT_W'(1);
        end
    end

    always_comb begin
        level = '0;
        for (int i = 0; i < 3; i++)
            level[i] = (cnt[i] == CNT_W'(FILTER_CYCLES));
    end
`else
    logic [2:0] sample;

    always_ff @(posedge clk) begin
        sample <= coin_raw;
    end

    assign level = sample;
`endif

    // Loading the live levels at reset keeps an already-inserted coin from counting.
    always_ff @(posedge clk) begin
        if (!reset)
            level_prev <= coin_raw;
        else
            level_prev <= level;
    end

    assign events = level & ~level_prev;

    logic [SUM_W-1:0]  coin_sum;
    logic [SUM_W-1:0]  credit_sum;
    logic              coin_any;
    logic              coin_ok;
    logic [ITEM_W-1:0] sel_idx;
    logic              sel_valid;
    logic [SUM_W-1:0]  vend_price;

    always_comb begin
        coin_sum   = (events[0] ? SUM_W'(5)  : '0)
                   + (events[1] ? SUM_W'(10) : '0)
                   + (events[2] ? SUM_W'(25) : '0);
        coin_any   = (coin_sum != '0);
        credit_sum = {1'b0, credit_r} + coin_sum;
        coin_ok    = (credit_sum <= SUM_W'(MAX_CREDIT));
        sel_idx    = '0;
        for (int i = N_ITEMS - 1; i >= 0; i--)
            if (bus.select[i]) sel_idx = ITEM_W'(i);
        sel_valid  = (|bus.select) && (price(int'(sel_idx)) <= {1'b0, credit_r})
                     && (stock[sel_idx] != '0);
        vend_price = price(int'(item_r));
    end

    assign bus.credit = credit_r;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state             <= IDLE;
            credit_r          <= '0;
            item_r            <= '0;
            for (int i = 0; i < N_ITEMS; i++)
                stock[i] <= STOCK_W'(STOCK_INIT);
            bus.dispense      <= 1'b0;
            bus.dispense_item <= '0;
            bus.change_valid  <= 1'b0;
            bus.change_amt    <= '0;
            bus.coin_reject   <= 1'b0;
            bus.sold_out      <= (STOCK_INIT == 0) ? '1 : '0;
        end else begin
            bus.dispense      <= 1'b0;
            bus.dispense_item <= '0;
            bus.change_valid  <= 1'b0;
            bus.change_amt    <= '0;
            bus.coin_reject   <= 1'b0;
            for (int i = 0; i < N_ITEMS; i++)
                bus.sold_out[i] <= (stock[i] == '0);

            case (state)
                IDLE, CREDIT: begin
                    if (coin_any) begin
                        if (coin_ok) credit_r <= credit_sum[CREDIT_W-1:0];
                        else         bus.coin_reject <= 1'b1;
                    end
                    // Affordability uses the credit before this cycle's coins.
                    if (state == CREDIT && sel_valid) begin
                        state  <= VEND;
                        item_r <= sel_idx;
                    end else if (state == CREDIT && bus.refund) begin
                        state <= CHANGE;
                    end else if (coin_any && coin_ok) begin
                        state <= CREDIT;
                    end
                end
                VEND: begin
                    bus.coin_reject   <= coin_any;
                    bus.dispense      <= 1'b1;
                    bus.dispense_item <= item_r;
                    stock[item_r]     <= stock[item_r] - STOCK_W'(1);
                    credit_r          <= credit_r - vend_price[CREDIT_W-1:0];
                    state             <= CHANGE;
                end
                CHANGE: begin
                    bus.coin_reject <= coin_any;
                    if (credit_r != '0) begin
                        bus.change_valid <= 1'b1;
                        bus.change_amt   <= credit_r;
                    end
                    credit_r <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vending_ctrl_multi.sv
// tb/tb_vending_ctrl_multi.sv - scoreboard bench for vending_ctrl_multi; honours COIN_FILTER_EN
module tb_vending_ctrl_multi;
    localparam int N    = 4;
    localparam int PB   = 25;
    localparam int PS   = 10;
    localparam int CW   = 8;
    localparam int MAXC = 100;
    localparam int SW   = 4;
    localparam int SI   = 3;
    localparam int FC   = 2;
`ifdef COIN_FILTER_EN
    localparam int HOLD = FC;
`else
    localparam int HOLD = 1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vending_ctrl_multi_if #(.N_ITEMS(N), .CREDIT_W(CW)) bus();

    vending_ctrl_multi #(
        .N_ITEMS(N), .PRICE_BASE(PB), .PRICE_STEP(PS), .CREDIT_W(CW), .MAX_CREDIT(MAXC),
        .STOCK_W(SW), .STOCK_INIT(SI), .FILTER_CYCLES(FC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        int kind;
        int val;
    } ev_t;

    ev_t          exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    bit           mon_en   = 1'b0;
    int           m_credit;
    int           m_stock[N];
    logic [N-1:0] sel_held;

    function automatic int price(input int i);
        return PB + i * PS;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_ev(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic expect_ev(input int kind, input int val);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_strobe: got kind %0d value %0d expected none", kind, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val) begin
                n_fail++;
                $display("FAIL strobe: got kind %0d value %0d expected kind %0d value %0d",
                         kind, val, e.kind, e.val);
            end
        end
    endtask

    // kind 0 = dispense(item), 1 = change(amount), 2 = coin reject
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.dispense)     expect_ev(0, int'(bus.dispense_item));
            if (bus.change_valid) expect_ev(1, int'(bus.change_amt));
            if (bus.coin_reject)  expect_ev(2, 0);
        end
    end

    task automatic model_reset();
        m_credit = 0;
        for (int i = 0; i < N; i++) m_stock[i] = SI;
    endtask

    task automatic model_select();
        int s;
        s = -1;
        for (int i = N - 1; i >= 0; i--) if (sel_held[i]) s = i;
        if (s >= 0 && m_credit > 0 && price(s) <= m_credit && m_stock[s] > 0) begin
            push_ev(0, s);
            if (m_credit - price(s) > 0) push_ev(1, m_credit - price(s));
            m_stock[s]--;
            m_credit = 0;
        end
    endtask

    task automatic model_coins(input logic [2:0] c);
        int sum;
        sum = (c[0] ? 5 : 0) + (c[1] ? 10 : 0) + (c[2] ? 25 : 0);
        if (sum != 0) begin
            if (m_credit + sum <= MAXC) m_credit += sum;
            else                        push_ev(2, 0);
        end
    endtask

    task automatic settle();
        repeat (10) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        int mask;
        mask = 0;
        for (int i = 0; i < N; i++) if (m_stock[i] == 0) mask |= (1 << i);
        check({tag, "_credit"}, int'(bus.credit), m_credit);
        check({tag, "_sold_out"}, int'(bus.sold_out), mask);
    endtask

    task automatic put_coins(input logic [2:0] c);
        model_coins(c);
        model_select();
        @(negedge clk);
        {bus.coin_25, bus.coin_10, bus.coin_5} = c;
        repeat (HOLD) @(negedge clk);
        {bus.coin_25, bus.coin_10, bus.coin_5} = 3'b000;
        settle();
        check_state("coin");
    endtask

    task automatic do_select(input logic [N-1:0] s, input bit keep);
        @(negedge clk);
        bus.select = s;
        sel_held   = s;
        model_select();
        settle();
        if (!keep) begin
            bus.select = '0;
            sel_held   = '0;
        end
        check_state("select");
    endtask

    task automatic release_select();
        @(negedge clk);
        bus.select = '0;
        sel_held   = '0;
    endtask

    task automatic do_refund();
        if (m_credit > 0) push_ev(1, m_credit);
        m_credit = 0;
        @(negedge clk);
        bus.refund = 1'b1;
        @(negedge clk);
        bus.refund = 1'b0;
        settle();
        check_state("refund");
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        settle();
        check_state("reset");
    endtask

    initial begin
        int r;
        bus.coin_5  = 1'b0;
        bus.coin_10 = 1'b0;
        bus.coin_25 = 1'b0;
        bus.select  = '0;
        bus.refund  = 1'b0;
        sel_held    = '0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_credit", int'(bus.credit), 0);
        check("rst_sold_out", int'(bus.sold_out), 0);
        check("rst_dispense", int'(bus.dispense), 0);
        check("rst_dispense_item", int'(bus.dispense_item), 0);
        check("rst_change_valid", int'(bus.change_valid), 0);
        check("rst_change_amt", int'(bus.change_amt), 0);
        check("rst_coin_reject", int'(bus.coin_reject), 0);
        reset  = 1'b1;
        mon_en = 1'b1;

        // a coin already high across reset must not count
        @(negedge clk);
        bus.coin_10 = 1'b1;
        do_reset();
        bus.coin_10 = 1'b0;
        settle();
        check_state("coin_high_at_reset");

        put_coins(3'b010);
        put_coins(3'b010);
        do_select(4'b0001, 1'b1);
        put_coins(3'b001);
        release_select();

        put_coins(3'b011);
        check("reject_clear", int'(bus.coin_reject), 0);
        do_refund();

        do_select(4'b0010, 1'b1);
        put_coins(3'b100);
        put_coins(3'b100);
        release_select();

        while (m_stock[0] > 0) begin
            put_coins(3'b100);
            do_select(4'b0001, 1'b0);
        end
        put_coins(3'b100);
        do_select(4'b0001, 1'b0);
        do_refund();

        repeat (4) put_coins(3'b100);
        put_coins(3'b001);
        do_reset();

`ifdef COIN_FILTER_EN
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            #1 bus.coin_25 = 1'b1;
            #2 bus.coin_25 = 1'b0;
        end
        @(negedge clk);
        bus.coin_25 = 1'b1;
        repeat (FC - 1) @(negedge clk);
        bus.coin_25 = 1'b0;
        settle();
        check_state("glitch");
        model_coins(3'b100);
        @(negedge clk);
        bus.coin_25 = 1'b1;
        repeat (FC + 1) @(negedge clk);
        bus.coin_25 = 1'b0;
        settle();
        check_state("filtered_coin");
        do_refund();
`endif

        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 9);
            if (r <= 4)
                put_coins(3'($urandom_range(1, 7)));
            else if (r <= 7)
                do_select(N'($urandom_range(1, (1 << N) - 1)), 1'($urandom_range(0, 1)));
            else if (r == 8)
                do_refund();
            else if ($urandom_range(0, 2) == 0)
                do_reset();
            else
                release_select();
        end

        release_select();
        do_refund();
        check("pending_events", exp_q.size(), 0);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vending_ctrl_multi.md
# vending_ctrl_multi

Parametrised multi-item vending controller, the successor to the single-product `retro_vending` FSM. It accepts 5/10/25-cent coin pulses with edge detection and an optional glitch filter, and accumulates credit with an overflow guard. It serves N_ITEMS products, each with its own price and stock counter, and issues a one-cycle dispense strobe followed by a change/refund strobe. It sits between the coin-mech/button front end and the dispenser/change-hopper drivers.

## Interface
- `N_ITEMS`, 4: number of products; item i price = PRICE_BASE + i*PRICE_STEP
- `PRICE_BASE`, 25: price of item 0, in cents
- `PRICE_STEP`, 10: price increment per item index
- `CREDIT_W`, 8: width of credit and change values
- `MAX_CREDIT`, 100: credit ceiling; must be < 2**CREDIT_W
- `STOCK_W`, 4: width of each stock counter
- `STOCK_INIT`, 3: stock loaded into every item at reset
- `FILTER_CYCLES`, 2: consecutive high samples required per coin (used only with `COIN_FILTER_EN`)

Ports:
- `clk`, input, 1: rising-edge clock
- `reset`, input, 1: synchronous, active-low reset
- `coin_5` / `coin_10` / `coin_25`, input, 1 each: coin-mech levels; asynchronous to the FSM meaning, sampled on `clk`
- `select`, input, N_ITEMS: item request, level-sensitive; if multi-hot, the lowest index wins
- `refund`, input, 1: level; returns all credit
- `dispense`, output, 1: one-cycle vend strobe
- `dispense_item`, output, $clog2(N_ITEMS): item index, valid while `dispense`=1
- `change_valid`, output, 1: one-cycle change/refund strobe
- `change_amt`, output, CREDIT_W: change amount, valid while `change_valid`=1
- `credit`, output, CREDIT_W: current credit
- `sold_out`, output, N_ITEMS: bit i high when stock[i]==0
- `coin_reject`, output, 1: one-cycle strobe; coin(s) refused

## Operation
- Reset (`reset`=0 at a clk edge) has priority over everything:
  - state=IDLE, credit=0, every stock=STOCK_INIT.
  - All strobes=0, `dispense_item`=0, `change_amt`=0, `sold_out`=0 (or all-ones if STOCK_INIT=0).
  - The edge-detect history registers load the current coin levels, so a coin that is already high does not count.
  - A reset in the middle of a vend drops credit without a change strobe.
- Coin event: rising edge of the coin level (or of the filtered level), registered against the previous sample.
  - All events that fall in the same cycle are summed (max 40).
- Accepting coins, in IDLE/CREDIT:
  - If credit + sum ≤ MAX_CREDIT, add the sum and go to CREDIT.
  - Otherwise reject every coin of that cycle: `coin_reject`=1 and credit unchanged.
  - Coin events in VEND/CHANGE are rejected the same way.
- States:
  - IDLE (credit=0) → CREDIT on an accepted coin.
  - CREDIT → VEND when a select target s exists with price[s] ≤ credit (coins added in the same cycle are not yet counted) and stock[s]≠0. Selects of unaffordable or sold-out items are ignored without error, and the FSM stays in its state.
  - CREDIT → CHANGE on `refund` with no valid select; change = credit. A valid select beats refund in the same cycle.
  - VEND: `dispense`=1, `dispense_item`=s, stock[s]−=1, credit−=price[s]; then → CHANGE.
  - CHANGE: `change_valid`=1 and `change_amt`=credit only when credit≠0, then credit=0; → IDLE.
  - `refund` in IDLE is ignored.
- Arithmetic:
  - All sums are computed at CREDIT_W+1 bits before the ceiling compare; no wrap.
  - Price table is elaborated as constants; the designer checks price ≤ MAX_CREDIT.

## Timing
- Coin edge sampled at edge t → `credit` updated at edge t+1.
- Valid select at edge t → `dispense`=1 during t+1..t+2, then change strobe during t+2..t+3, then `credit`=0.
- Select held continuously vends exactly once per purchase. After CHANGE it vends again only if new credit suffices.
- `sold_out` is registered and updates the cycle after the stock decrement.
- A coin held high for many cycles counts once; back-to-back pulses separated by ≥1 low sample count individually.

## Configuration
- `COIN_FILTER_EN` defined: each coin input passes through a saturating counter.
  - The filtered level rises after FILTER_CYCLES consecutive high samples and falls on the first low sample.
  - Glitches shorter than FILTER_CYCLES clocks are never counted.
  - Latency from coin high to credit = FILTER_CYCLES+1 cycles.
- `COIN_FILTER_EN` undefined: raw sampled levels feed edge detection directly; every sampled high run counts as one coin.

## Test plan
- Two coin_10 pulses, each 1 clk high with 1 clk low between → credit 10 then 20; select[0] held → no dispense. Add coin_5 → credit 25, dispense_item=0, no change_valid, credit 0.
- coin_5 and coin_10 rising in the same cycle → credit 15, coin_reject=0.
- Noise, with `COIN_FILTER_EN` and FILTER_CYCLES=2: coin_25 2 ns glitches, then 1-clk high → credit 0; coin_25 held 3 clks → credit 25 exactly once.
- Early select: select[1] held, coin_25 → no vend. Second coin_25 (credit 50) → dispense_item=1, change_amt=15, credit 0.
- Stock: three vends of item 0 → sold_out[0]=1. A fourth select[0] with credit 25 is ignored; refund → change_amt=25.
- Credit 100, then coin_5 → coin_reject pulse, credit stays 100. Then reset low for 1 clk mid-CREDIT → credit 0, stocks=3, no strobes.
